// File: rtl/lcd_frame_writer.sv
// HD44780 16x2 frame writer: power-on init, sequential double-dabble of a
// captured result, then a full two-line frame with EN/RS/data strobing.
module lcd_frame_writer #(
  parameter int W        = 16,
  parameter int DIGITS   = 5,
  parameter int SIGNED   = 1,
  parameter int TICKS    = 50_000,
  parameter int CLR_WAIT = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   opcode,
  input  logic [3:0]   reg_id,
  input  logic [W-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         EN,
  output logic         RS,
  output logic         RW,
  output logic [7:0]   data
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0] T_LAST = 32'(TICKS - 1);
  localparam logic [31:0] C_LAST = 32'(CLR_WAIT - 1);
  localparam logic [31:0] V_LAST = 32'(W - 1);
  localparam logic [3:0]  PAD    = 4'(15 - DIGITS);
  // BCD digits above the displayed ones; any set bit there means overflow
  localparam logic [39:0] HI_MASK = ~((40'd1 << (4 * DIGITS)) - 40'd1);

  logic [2:0]   state_r, next_state_s;
  logic [31:0]  cnt_r, wait_last_s;
  logic [5:0]   idx_r, sel_idx_s, last_idx_s;
  logic         load_s, init_mode_r;
  logic [2:0]   op_r;
  logic [3:0]   reg_r;
  logic         neg_r, neg_s;
  logic [W-1:0] mag_r;
  logic [39:0]  bcd_r, dd_s;
  logic         en_r, rs_r, done_r, busy_r;
  logic [7:0]   data_r;
  logic [8:0]   byte_s;
  logic [3:0]   c1_s, c2_s, tens_s, ones_s, dig_s;
  logic [39:0]  mn_s, mn_sh_s;
  logic [7:0]   sign_s;
  logic         ovf_s, clr_s;

  assign busy = busy_r;
  assign done = done_r;
  assign EN   = en_r;
  assign RS   = rs_r;
  assign RW   = 1'b0;
  assign data = data_r;

  assign neg_s = (SIGNED != 0) && result[W-1];

  // Phase sequencer: decides the next state and when a new byte is loaded
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    sel_idx_s    = idx_r + 6'd1;
    last_idx_s   = init_mode_r ? 6'd3 : 6'd34;
    wait_last_s  = (!rs_r && (data_r == 8'h01)) ? C_LAST : T_LAST;
    case (state_r)
      S_INIT: begin
        next_state_s = S_WRITE;
        load_s       = 1'b1;
        sel_idx_s    = 6'd0;
      end
      S_IDLE: begin
        if (start) next_state_s = S_CONV;
        else       next_state_s = S_IDLE;
      end
      S_CONV: begin
        if (cnt_r == V_LAST) begin
          next_state_s = S_WRITE;
          load_s       = 1'b1;
          sel_idx_s    = 6'd0;
        end else begin
          next_state_s = S_CONV;
        end
      end
      S_WRITE: begin
        if (cnt_r == T_LAST) next_state_s = S_WAIT;
        else                 next_state_s = S_WRITE;
      end
      S_WAIT: begin
        if (cnt_r == wait_last_s) begin
          if (idx_r == last_idx_s) begin
            next_state_s = init_mode_r ? S_IDLE : S_DONE;
          end else begin
            next_state_s = S_WRITE;
            load_s       = 1'b1;
          end
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_INIT;
    endcase
  end

  // One double-dabble adjust step over all ten BCD digits
  always_comb begin
    dd_s = bcd_r;
    for (int k = 0; k < 10; k++) begin
      if (dd_s[4*k +: 4] > 4'd4) dd_s[4*k +: 4] = dd_s[4*k +: 4] + 4'd3;
      else                       dd_s[4*k +: 4] = dd_s[4*k +: 4];
    end
  end

  // Padded five-character mnemonic for the captured opcode
  always_comb begin
    case (op_r)
      3'd0:    mn_s = 40'h4C4F414420;
      3'd1:    mn_s = 40'h4144442020;
      3'd2:    mn_s = 40'h4144444920;
      3'd3:    mn_s = 40'h5355422020;
      3'd4:    mn_s = 40'h5355424920;
      3'd5:    mn_s = 40'h4D554C2020;
      3'd6:    mn_s = 40'h434C454152;
      default: mn_s = 40'h4449535020;
    endcase
  end

  // {RS, data} of the byte at sel_idx_s
  always_comb begin
    c1_s    = 4'(sel_idx_s - 6'd2);
    c2_s    = 4'(sel_idx_s - 6'd19);
    clr_s   = (op_r == 3'd6);
    tens_s  = (reg_r >= 4'd10) ? 4'd1 : 4'd0;
    ones_s  = (reg_r >= 4'd10) ? (reg_r - 4'd10) : reg_r;
    dig_s   = 4'(bcd_r >> {4'd15 - c2_s, 2'b00});
    ovf_s   = |(bcd_r & HI_MASK);
    mn_sh_s = mn_s << {c1_s[2:0], 3'b000};
    sign_s  = neg_r ? 8'h2D : ((SIGNED != 0) ? 8'h2B : 8'h20);
    if (init_mode_r) begin
      case (sel_idx_s[1:0])
        2'd0:    byte_s = 9'h038;
        2'd1:    byte_s = 9'h00C;
        2'd2:    byte_s = 9'h006;
        default: byte_s = 9'h001;
      endcase
    end else if (sel_idx_s == 6'd0) begin
      byte_s = 9'h001;
    end else if (sel_idx_s == 6'd1) begin
      byte_s = 9'h080;
    end else if (sel_idx_s <= 6'd17) begin
      if (c1_s < 4'd5)       byte_s = {1'b1, mn_sh_s[39:32]};
      else if (c1_s < 4'd11) byte_s = 9'h120;
      else if (clr_s)        byte_s = 9'h120;
      else begin
        case (c1_s)
          4'd11:   byte_s = 9'h15B;
          4'd12:   byte_s = 9'h152;
          4'd13:   byte_s = {5'b1_0011, tens_s};
          4'd14:   byte_s = {5'b1_0011, ones_s};
          default: byte_s = 9'h15D;
        endcase
      end
    end else if (sel_idx_s == 6'd18) begin
      byte_s = 9'h0C0;
    end else begin
      if (clr_s)              byte_s = 9'h120;
      else if (c2_s < PAD)    byte_s = 9'h120;
      else if (c2_s == PAD)   byte_s = {1'b1, sign_s};
      else if (ovf_s)         byte_s = 9'h12A;
      else                    byte_s = {5'b1_0011, dig_s};
    end
  end

  // State, phase counter, byte index and registered LCD/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_INIT;
      cnt_r       <= 32'd0;
      idx_r       <= 6'd0;
      init_mode_r <= 1'b1;
      en_r        <= 1'b0;
      rs_r        <= 1'b0;
      data_r      <= 8'h00;
      done_r      <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r <= next_state_s;
      en_r    <= (next_state_s == S_WRITE);
      busy_r  <= (next_state_s != S_IDLE);
      done_r  <= (next_state_s == S_DONE);
      if ((state_r == S_CONV || state_r == S_WRITE || state_r == S_WAIT) &&
          (next_state_s == state_r) && !load_s)
        cnt_r <= cnt_r + 32'd1;
      else
        cnt_r <= 32'd0;
      if (load_s) begin
        idx_r  <= sel_idx_s;
        data_r <= byte_s[7:0];
        rs_r   <= byte_s[8];
      end
      if (state_r == S_IDLE) init_mode_r <= 1'b0;
    end
  end

  // Request capture and the W-cycle shift-and-add-3 conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 3'd0;
      reg_r <= 4'd0;
      neg_r <= 1'b0;
      mag_r <= '0;
      bcd_r <= 40'd0;
    end else if (state_r == S_IDLE && start) begin
      op_r  <= opcode;
      reg_r <= reg_id;
      neg_r <= neg_s;
      mag_r <= neg_s ? ((~result) + W'(1)) : result;
      bcd_r <= 40'd0;
    end else if (state_r == S_CONV) begin
      bcd_r <= {dd_s[38:0], mag_r[W-1]};
      mag_r <= mag_r << 1;
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed + randomized bench for lcd_frame_writer; frames are compared against
// a string-based reference of the two display lines and per-byte phase timing.
module tb_lcd_frame_writer;

  localparam int T  = 2;
  localparam int CW = 4;
  localparam int W  = 16;
  localparam int D  = 5;
  localparam int WU = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, start_u;
  logic [2:0]    op, op_u;
  logic [3:0]    rid, rid_u;
  logic [W-1:0]  res;
  logic [WU-1:0] res_u;
  logic          busy, done, en, rs, rw, busy_u, done_u, en_u, rs_u, rw_u;
  logic [7:0]    data, data_u;

  lcd_frame_writer #(.W(W), .DIGITS(D), .SIGNED(1), .TICKS(T), .CLR_WAIT(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(op), .reg_id(rid), .result(res),
    .busy(busy), .done(done), .EN(en), .RS(rs), .RW(rw), .data(data));

  lcd_frame_writer #(.W(WU), .DIGITS(D), .SIGNED(0), .TICKS(T), .CLR_WAIT(CW)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .opcode(op_u), .reg_id(rid_u), .result(res_u),
    .busy(busy_u), .done(done_u), .EN(en_u), .RS(rs_u), .RW(rw_u), .data(data_u));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] byte_q[$], byte_uq[$], exp_q[$];
  int rise_q[$], rise_uq[$], hi_q[$], hi_uq[$], done_q[$], done_uq[$];
  logic en_p = 1'b0, en_up = 1'b0;

  // Record every byte strobe, its EN-high length and every done pulse
  always @(negedge clk) begin
    if (en && !en_p) begin byte_q.push_back({rs, data}); rise_q.push_back(cyc); end
    if (!en && en_p && rise_q.size() > 0) hi_q.push_back(cyc - rise_q[$]);
    if (done) done_q.push_back(cyc);
    en_p = en;
    if (en_u && !en_up) begin byte_uq.push_back({rs_u, data_u}); rise_uq.push_back(cyc); end
    if (!en_u && en_up && rise_uq.size() > 0) hi_uq.push_back(cyc - rise_uq[$]);
    if (done_u) done_uq.push_back(cyc);
    en_up = en_u;
  end

  string mn[8] = '{"LOAD ", "ADD  ", "ADDI ", "SUB  ", "SUBI ", "MUL  ", "CLEAR", "DISP "};

  task automatic chk(string tag, longint obs, longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    byte_q.delete(); rise_q.delete(); hi_q.delete(); done_q.delete();
    byte_uq.delete(); rise_uq.delete(); hi_uq.delete(); done_uq.delete();
  endtask

  function automatic void build_frame(int o, int r, longint unsigned v, int w, bit sgn);
    string l1, l2, sc;
    longint sv, mag, lim, p;
    bit neg;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    lim = lim - 1;
    sv = longint'(v);
    if (sgn && v[w-1]) sv = sv - (longint'(1) << w);
    neg = (sv < 0);
    mag = neg ? -sv : sv;
    if (o == 6) l1 = {mn[o], "           "};
    else        l1 = {mn[o], "      ", $sformatf("[R%02d]", r)};
    l2 = "";
    for (int i = 0; i < 15 - D; i++) l2 = {l2, " "};
    if (neg)      sc = "-";
    else if (sgn) sc = "+";
    else          sc = " ";
    l2 = {l2, sc};
    for (int i = D - 1; i >= 0; i--) begin
      p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      if (mag > lim) l2 = {l2, "*"};
      else           l2 = {l2, $sformatf("%0d", (mag / p) % 10)};
    end
    if (o == 6) l2 = "                ";
    exp_q.delete();
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(l1[i])});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(l2[i])});
  endfunction

  task automatic check_frame(string tag, logic [8:0] bq[$], int rq[$], int hq[$], int dq[$],
                             int s0, int w);
    int t;
    t = s0 + w;
    chk({tag, " byte count"}, bq.size(), exp_q.size());
    chk({tag, " done count"}, dq.size(), 1);
    if (bq.size() == exp_q.size() && rq.size() == exp_q.size() && hq.size() == exp_q.size()) begin
      chk({tag, " first write"}, rq[0], s0 + w);
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("%s byte %0d", tag, i), bq[i], exp_q[i]);
        chk($sformatf("%s en_high %0d", tag, i), hq[i], T);
        if (i > 0) chk($sformatf("%s spacing %0d", tag, i), rq[i] - rq[i-1],
                       T + ((exp_q[i-1] == 9'h001) ? CW : T));
        t = t + T + ((exp_q[i] == 9'h001) ? CW : T);
      end
      if (dq.size() > 0) chk({tag, " done cycle"}, dq[0], t);
    end
  endtask

  task automatic init_release(string tag);
    logic [8:0] ib[4];
    int rel;
    ib = '{9'h038, 9'h00C, 9'h006, 9'h001};
    clear_mon();
    rel = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 500 && busy; i++) step();
    chk({tag, " busy fall"}, cyc, rel + 1 + 3 * 2 * T + T + CW);
    chk({tag, " init bytes"}, byte_q.size(), 4);
    chk({tag, " no done"}, done_q.size(), 0);
    if (byte_q.size() == 4 && hi_q.size() == 4) begin
      chk({tag, " first rise"}, rise_q[0], rel + 1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s init byte %0d", tag, i), byte_q[i], ib[i]);
        chk($sformatf("%s init en %0d", tag, i), hi_q[i], T);
      end
    end
  endtask

  task automatic frame(int o, int r, logic [W-1:0] v, bit glitch, string tag);
    int s0;
    step();
    clear_mon();
    build_frame(o, r, v, W, 1'b1);
    op = 3'(o); rid = 4'(r); res = v; start = 1'b1;
    step();
    s0 = cyc;
    start = 1'b0;
    op = 3'($urandom); rid = 4'($urandom); res = W'($urandom);
    if (glitch) begin
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 500 && rise_q.size() < 5; i++) step();
      start = 1'b1; op = 3'($urandom); res = W'($urandom);
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 2000 && done_q.size() == 0; i++) step();
    repeat (glitch ? 60 : 3) step();
    chk({tag, " busy idle"}, busy, 0);
    check_frame(tag, byte_q, rise_q, hi_q, done_q, s0, W);
  endtask

  task automatic frame_u(int o, int r, logic [WU-1:0] v, string tag);
    int s0;
    step();
    clear_mon();
    build_frame(o, r, v, WU, 1'b0);
    op_u = 3'(o); rid_u = 4'(r); res_u = v; start_u = 1'b1;
    step();
    s0 = cyc;
    start_u = 1'b0;
    res_u = WU'($urandom);
    for (int i = 0; i < 2000 && done_uq.size() == 0; i++) step();
    repeat (3) step();
    check_frame(tag, byte_uq, rise_uq, hi_uq, done_uq, s0, WU);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_u = 1'b0;
    op = 3'd0; rid = 4'd0; res = '0; op_u = 3'd0; rid_u = 4'd0; res_u = '0;
    repeat (2) step();
    chk("rst EN", en, 0);
    chk("rst RS", rs, 0);
    chk("rst RW", rw, 0);
    chk("rst data", data, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 1);
    init_release("init");
    repeat (4) step();

    frame(1, 5, 16'h0123, 1'b0, "add_r5");
    frame(3, 12, 16'hFFFF, 1'b0, "sub_m1");
    frame(3, 12, 16'h8000, 1'b0, "sub_min");
    frame(6, 9, W'($urandom), 1'b0, "clear");
    frame(2, 7, 16'h7FFF, 1'b1, "glitch");
    for (int n = 0; n < 4; n++)
      frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), W'($urandom), 1'b0,
            $sformatf("rand%0d", n));

    frame_u(0, 3, 20'd200000, "u_ovf");
    frame_u(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            WU'($urandom_range(0, 99999)), "u_rand");

    // abort mid-frame at the 20th byte
    step();
    clear_mon();
    op = 3'd5; rid = 4'd2; res = W'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 1000 && rise_q.size() < 20; i++) step();
    chk("abort reached byte 20", rise_q.size(), 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort EN async", en, 0);
    chk("abort data async", data, 0);
    chk("abort no done", done_q.size(), 0);
    repeat (2) step();
    init_release("reinit");
    repeat (40) step();
    chk("reinit still no done", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
